// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store sequencer. It checks alignment, runs one
// req/ack data-bus transaction per request and drives the load data extender.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_valid,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_signed,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_bus,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  ext_a,
  output logic [2:0]  ext_op,
  output logic [31:0] ext_din,
  input  logic [31:0] ext_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam bit          TO_EN  = (TIMEOUT != 0);
  localparam logic [31:0] TO_LIM = TO_EN ? 32'(TIMEOUT - 1) : 32'd0;

  state_t      state;
  logic [31:0] tcnt;
  logic        ld_ok;
  logic        expired;

  logic        misaligned;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [2:0]  op_n;

  // Request decode: alignment check, byte lanes and extender op.
  always_comb begin
    misaligned = 1'b0;
    be_n       = 4'b1111;
    wdata_n    = lsu_wdata;
    op_n       = 3'b000;
    case (lsu_size)
      2'd0: begin
        be_n    = 4'b0001 << lsu_addr[1:0];
        wdata_n = {4{lsu_wdata[7:0]}};
        op_n    = lsu_signed ? 3'b010 : 3'b001;
      end
      2'd1: begin
        misaligned = lsu_addr[0];
        be_n       = lsu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n    = {2{lsu_wdata[15:0]}};
        op_n       = lsu_signed ? 3'b100 : 3'b011;
      end
      default: begin
        misaligned = |lsu_addr[1:0];
      end
    endcase
  end

  assign expired   = TO_EN && (tcnt == TO_LIM);
  assign lsu_stall = lsu_valid & ~lsu_done;
  assign lsu_rdata = (lsu_done && ld_ok) ? ext_dout : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tcnt      <= '0;
      ld_ok     <= 1'b0;
      lsu_done  <= 1'b0;
      exc_adel  <= 1'b0;
      exc_ades  <= 1'b0;
      exc_bus   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      ext_a     <= '0;
      ext_op    <= '0;
      ext_din   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_valid) begin
            if (misaligned) begin
              exc_adel <= ~lsu_we;
              exc_ades <= lsu_we;
              lsu_done <= 1'b1;
              state    <= DONE;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= lsu_we;
              mem_addr  <= {lsu_addr[31:2], 2'b00};
              mem_be    <= be_n;
              mem_wdata <= wdata_n;
              ext_a     <= lsu_addr[1:0];
              ext_op    <= op_n;
              tcnt      <= '0;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // An ack in the expiry cycle takes priority over the timeout.
          if (mem_ack) begin
            mem_req  <= 1'b0;
            lsu_done <= 1'b1;
            if (!mem_we) begin
              ext_din <= mem_rdata;
              ld_ok   <= 1'b1;
            end
            state <= DONE;
          end else if (expired) begin
            mem_req  <= 1'b0;
            exc_bus  <= 1'b1;
            lsu_done <= 1'b1;
            state    <= DONE;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        DONE: begin
          lsu_done <= 1'b0;
          exc_adel <= 1'b0;
          exc_ades <= 1'b0;
          exc_bus  <= 1'b0;
          ld_ok    <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
